// File: rtl/complex_divider_seq.sv
// -----------------------------------------------------------------------------
// complex_divider_seq
//
// Sequential fixed-point complex divider: result = a / b for signed W-bit
// complex operands. The quotient is returned as two signed OW-bit parts with
// FRAC fractional bits.
//
// Method:
//   a / b = (a * conj(b)) / |b|^2
//     Nr = ar*br + ai*bi,  Ni = ai*br - ar*bi,  D = br^2 + bi^2
//   Each part is computed as trunc((N << FRAC) / D), rounding toward zero.
//   One restoring-division engine per part runs in lock-step on a shared D and
//   produces one quotient bit per cycle. The sign is reapplied and the result
//   is saturated to OW bits on the way into the output registers.
//
// Flow:  IDLE -> PREP -> DIV (Q cycles) -> DONE -> IDLE
//   Only one division is in flight. in_ready is low from the accepting edge
//   until the cycle after the result handoff.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands (registered)
//   a_real       dividend real part, signed W bits
//   a_imag       dividend imaginary part, signed W bits
//   b_real       divisor real part, signed W bits
//   b_imag       divisor imaginary part, signed W bits
//   out_valid    result valid, held until accepted
//   out_ready    downstream accepts result
//   result_real  quotient real part, signed OW bits, FRAC fractional bits
//   result_imag  quotient imaginary part, signed OW bits, FRAC fractional bits
//   div_by_zero  b was 0+0i for this result
//   sat          either part saturated for this result
// -----------------------------------------------------------------------------
module complex_divider_seq #(
  parameter int W    = 8,
  parameter int OW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a_real,
  input  logic signed [W-1:0]  a_imag,
  input  logic signed [W-1:0]  b_real,
  input  logic signed [W-1:0]  b_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] result_real,
  output logic signed [OW-1:0] result_imag,
  output logic                 div_by_zero,
  output logic                 sat
);

  // NW: width of numerators and denominator; Q: quotient bits / iterations;
  // RW: partial remainder width (one bit wider than D for the trial subtract).
  localparam int NW = 2 * W + 1;
  localparam int Q  = NW + FRAC;
  localparam int RW = NW + 1;
  localparam int CW = $clog2(Q);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;

  // Captured operands
  logic signed [W-1:0] ar, ai, br, bi;

  // Preparation arithmetic (combinational from captured operands)
  logic signed [NW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [NW-1:0] nr_c, ni_c;
  logic        [NW-1:0] d_c;
  logic        [NW-1:0] nr_mag, ni_mag;

  // Division engine state: dvd_* holds the remaining dividend bits at the top
  // and the quotient bits collected so far at the bottom.
  logic [NW-1:0] d;
  logic [Q-1:0]  dvd_r, dvd_i;
  logic [RW-1:0] rem_r, rem_i;
  logic          neg_r, neg_i;

  logic [Q-1:0]  dvd_r_nxt, dvd_i_nxt;
  logic [RW-1:0] rem_r_nxt, rem_i_nxt;

  // Final result candidates
  logic [OW-1:0] res_r_c, res_i_c;
  logic          sat_r_c, sat_i_c;

  // One restoring-division iteration: bring down the next dividend bit,
  // subtract D if it fits, and shift the quotient bit in at the bottom.
  function automatic logic [RW+Q-1:0] div_step(
    input logic [RW-1:0] rem,
    input logic [Q-1:0]  dvd,
    input logic [NW-1:0] dv
  );
    logic [RW-1:0] trial;
    logic          qb;
    trial = {rem[RW-2:0], dvd[Q-1]};
    qb    = (trial >= {1'b0, dv});
    if (qb) begin
      trial = trial - {1'b0, dv};
    end
    return {trial, dvd[Q-2:0], qb};
  endfunction

  // Reapply sign to a quotient magnitude and clamp to OW bits.
  // Returns {saturated, value}. A negative magnitude of exactly 2^(OW-1)
  // is representable and is not saturation.
  function automatic logic [OW:0] sign_sat(
    input logic [Q-1:0] mag,
    input logic         neg
  );
    logic [Q-1:0]  pos_lim;
    logic [Q-1:0]  neg_lim;
    logic [OW-1:0] low;
    pos_lim = {{(Q-OW+1){1'b0}}, {(OW-1){1'b1}}};
    neg_lim = pos_lim + {{(Q-1){1'b0}}, 1'b1};
    low     = mag[OW-1:0];
    if (!neg) begin
      if (mag > pos_lim) begin
        return {1'b1, 1'b0, {(OW-1){1'b1}}};
      end
      return {1'b0, low};
    end
    if (mag > neg_lim) begin
      return {1'b1, 1'b1, {(OW-1){1'b0}}};
    end
    return {1'b0, -low};
  endfunction

  always_comb begin
    ar_x   = NW'(ar);
    ai_x   = NW'(ai);
    br_x   = NW'(br);
    bi_x   = NW'(bi);
    nr_c   = ar_x * br_x + ai_x * bi_x;
    ni_c   = ai_x * br_x - ar_x * bi_x;
    d_c    = unsigned'(br_x * br_x + bi_x * bi_x);
    nr_mag = nr_c[NW-1] ? unsigned'(-nr_c) : unsigned'(nr_c);
    ni_mag = ni_c[NW-1] ? unsigned'(-ni_c) : unsigned'(ni_c);
  end

  always_comb begin
    {rem_r_nxt, dvd_r_nxt} = div_step(rem_r, dvd_r, d);
    {rem_i_nxt, dvd_i_nxt} = div_step(rem_i, dvd_i, d);
    {sat_r_c, res_r_c}     = sign_sat(dvd_r_nxt, neg_r);
    {sat_i_c, res_i_c}     = sign_sat(dvd_i_nxt, neg_i);
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      result_real <= '0;
      result_imag <= '0;
      div_by_zero <= 1'b0;
      sat         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state    <= PREP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        PREP: begin
          if (d_c == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result_real <= '0;
            result_imag <= '0;
            div_by_zero <= 1'b1;
            sat         <= 1'b0;
          end else begin
            state <= DIV;
            count <= CW'(Q - 1);
          end
        end
        DIV: begin
          // The final iteration's quotient goes straight into the outputs.
          if (count == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result_real <= res_r_c;
            result_imag <= res_i_c;
            div_by_zero <= 1'b0;
            sat         <= sat_r_c | sat_i_c;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: loaded under FSM control, no reset needed
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          ar <= a_real;
          ai <= a_imag;
          br <= b_real;
          bi <= b_imag;
        end
      end
      PREP: begin
        d     <= d_c;
        neg_r <= nr_c[NW-1];
        neg_i <= ni_c[NW-1];
        dvd_r <= {nr_mag, {FRAC{1'b0}}};
        dvd_i <= {ni_mag, {FRAC{1'b0}}};
        rem_r <= '0;
        rem_i <= '0;
      end
      DIV: begin
        dvd_r <= dvd_r_nxt;
        dvd_i <= dvd_i_nxt;
        rem_r <= rem_r_nxt;
        rem_i <= rem_i_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_complex_divider_seq.sv
module tb_complex_divider_seq;

  localparam int W    = 8;
  localparam int OW   = 16;
  localparam int FRAC = 8;
  localparam int LAT_DIV = 2 * W + 1 + FRAC + 2;
  localparam int LAT_DBZ = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  a_real, a_imag, b_real, b_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] result_real, result_imag;
  logic                 div_by_zero;
  logic                 sat;

  int checks   = 0;
  int failures = 0;

  complex_divider_seq #(.W(W), .OW(OW), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_real      (a_real),
    .a_imag      (a_imag),
    .b_real      (b_real),
    .b_imag      (b_imag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_real (result_real),
    .result_imag (result_imag),
    .div_by_zero (div_by_zero),
    .sat         (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: plain integer complex division with truncation toward zero.
  function automatic longint clamp(input longint q, output logic s);
    s = 1'b0;
    if (q > 32767) begin
      s = 1'b1;
      return 32767;
    end
    if (q < -32768) begin
      s = 1'b1;
      return -32768;
    end
    return q;
  endfunction

  task automatic model(input int xar, input int xai, input int xbr, input int xbi,
                       output logic signed [OW-1:0] er, output logic signed [OW-1:0] ei,
                       output logic edbz, output logic esat);
    longint nr, ni, dd, qr, qi;
    logic sr, si;
    nr = xar * xbr + xai * xbi;
    ni = xai * xbr - xar * xbi;
    dd = xbr * xbr + xbi * xbi;
    if (dd == 0) begin
      er = '0; ei = '0; edbz = 1'b1; esat = 1'b0;
    end else begin
      qr = clamp((nr * (longint'(1) << FRAC)) / dd, sr);
      qi = clamp((ni * (longint'(1) << FRAC)) / dd, si);
      er = OW'(qr);
      ei = OW'(qi);
      edbz = 1'b0;
      esat = sr | si;
    end
  endtask

  task automatic offer(input logic signed [W-1:0] xar, input logic signed [W-1:0] xai,
                       input logic signed [W-1:0] xbr, input logic signed [W-1:0] xbi,
                       input string tag);
    int n;
    @(negedge clk);
    a_real = xar; a_imag = xai; b_real = xbr; b_imag = xbi;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scrambled operands after acceptance must have no effect.
    a_real = W'($urandom); a_imag = W'($urandom);
    b_real = W'($urandom); b_imag = W'($urandom);
  endtask

  task automatic run_op(input logic signed [W-1:0] xar, input logic signed [W-1:0] xai,
                        input logic signed [W-1:0] xbr, input logic signed [W-1:0] xbi,
                        input logic signed [OW-1:0] er, input logic signed [OW-1:0] ei,
                        input logic edbz, input logic esat, input int hold, input string tag);
    int  n;
    int  exp_lat;
    bit  seen_stall;
    offer(xar, xai, xbr, xbi, tag);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    exp_lat = edbz ? LAT_DBZ : LAT_DIV;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_real"}, 32'(result_real), 32'(er));
    chk({tag, "_imag"}, 32'(result_imag), 32'(ei));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    chk({tag, "_sat"}, 32'(sat), 32'(esat));
    chk({tag, "_inready_busy"}, 32'(in_ready), 32'd0);
    seen_stall = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a_real = W'($urandom); a_imag = W'($urandom);
      b_real = W'($urandom); b_imag = W'($urandom);
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1 && result_real === er && result_imag === ei &&
            div_by_zero === edbz && sat === esat && in_ready === 1'b0))
        seen_stall = 1'b1;
    end
    if (hold > 0) chk({tag, "_stall_stable"}, 32'(seen_stall), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_handoff"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic signed [OW-1:0] er, ei;
    logic edbz, esat;
    logic signed [W-1:0] rar, rai, rbr, rbi;
    bit spurious;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_real", 32'(result_real), 32'd0);
    chk("rst_imag", 32'(result_imag), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived results
    run_op(8'sd3, 8'sd4, 8'sd2, 8'sd2, 16'sd448, 16'sd64, 1'b0, 1'b0, 10, "d_3p4i_2p2i");
    run_op(8'sd1, 8'sd0, 8'sd0, 8'sd1, 16'sd0, -16'sd256, 1'b0, 1'b0, 0, "d_1_i");
    run_op(8'sd1, 8'sd0, 8'sd3, 8'sd0, 16'sd85, 16'sd0, 1'b0, 1'b0, 0, "d_1_3");
    run_op(-8'sd1, 8'sd0, 8'sd3, 8'sd0, -16'sd85, 16'sd0, 1'b0, 1'b0, 1, "d_m1_3");
    run_op(-8'sd128, 8'sd0, 8'sd1, 8'sd0, -16'sd32768, 16'sd0, 1'b0, 1'b0, 0, "d_m128_1");
    run_op(8'sd5, 8'sd5, 8'sd0, 8'sd0, 16'sd0, 16'sd0, 1'b1, 1'b0, 3, "d_dbz");
    run_op(-8'sd128, 8'sd0, -8'sd1, 8'sd0, 16'sd32767, 16'sd0, 1'b0, 1'b1, 0, "d_m128_m1");

    // Reset in the middle of a division
    offer(8'sd3, 8'sd4, 8'sd2, 8'sd2, "rst_mid");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_real", 32'(result_real), 32'd0);
    chk("midrst_imag", 32'(result_imag), 32'd0);
    chk("midrst_sat", 32'(sat), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    chk("midrst_no_result", 32'(spurious), 32'd0);
    run_op(8'sd3, 8'sd4, 8'sd2, 8'sd2, 16'sd448, 16'sd64, 1'b0, 1'b0, 0, "post_rst");

    // Randomized operands against the reference model
    for (int t = 0; t < 40; t++) begin
      rar = W'($urandom); rai = W'($urandom);
      rbr = W'($urandom); rbi = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rbr = '0; rbi = '0;
      end else if ($urandom_range(0, 3) == 0) begin
        rbr = W'($urandom_range(0, 2)) - W'(1);
        rbi = W'($urandom_range(0, 2)) - W'(1);
      end
      model(int'(rar), int'(rai), int'(rbr), int'(rbi), er, ei, edbz, esat);
      run_op(rar, rai, rbr, rbi, er, ei, edbz, esat, $urandom_range(0, 2),
             $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
